// File: rtl/iob_cycle_engine.sv
// iob_cycle_engine
//   Runs the I/O-bus half of a CPU access once the chip-select decoder has
//   raised IOCS. It drives a 68000-style asynchronous cycle on the IOB side
//   and ends the 68030 cycle in one of two ways. A normal end uses 16-bit
//   port sizing, with nDSACK1 only. If the optional timeout is built in, a
//   cycle that gets no acknowledge ends with nBERR instead.
//
//   Optional feature macro: IOB_TIMEOUT_BERR_EN
//     defined   : a WAITACK watchdog raises nBERR after TIMEOUT_CYCLES
//     undefined : WAITACK waits forever, nBERR is tied high, no counter
//
// Ports
//   CLK, nRES            clock, asynchronous active-low reset
//   IOCS                 decoder select, only looked at in IDLE
//   nAS, RnW, SIZ, A0    CPU address strobe, direction, size, address bit 0
//   IOB_nDTACK           IOB acknowledge (asynchronous, active low)
//   IOB_nAS/nUDS/nLDS    IOB address and data strobes (active low)
//   IOB_RnW, IOB_AOE     IOB direction, address buffer output enable
//   nDSACK1, nBERR       CPU termination / bus error (active low)
//   RDLatch              one-cycle pulse that captures IOB read data
module iob_cycle_engine #(
  parameter int SETUP_CYCLES   = 1,
  parameter int RECOVER_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       nRES,
  input  logic       IOCS,
  input  logic       nAS,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic       A0,
  input  logic       IOB_nDTACK,
  output logic       IOB_nAS,
  output logic       IOB_nUDS,
  output logic       IOB_nLDS,
  output logic       IOB_RnW,
  output logic       IOB_AOE,
  output logic       nDSACK1,
  output logic       nBERR,
  output logic       RDLatch
);

  // Out-of-range parameters stop elaboration on a missing module.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3 || RECOVER_CYCLES < 1 ||
      RECOVER_CYCLES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    iob_cycle_engine_illegal_parameter u_bad ();
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITACK, TERM, BERR, RECOVER} state_t;

  localparam logic [2:0] SETUP_LAST   = 3'(SETUP_CYCLES);
  localparam logic [2:0] RECOVER_LAST = 3'(RECOVER_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;          // shared by SETUP and RECOVER
  logic       rnw_lat;
  logic       uds_sel;
  logic       lds_sel;
  logic       dtack_meta;
  logic       dtack_sync;
  logic       ack;
  logic       abort;
  logic       cpu_done;

  assign ack = ~dtack_sync;

  // The CPU dropping its strobe before termination ends the cycle quietly.
  assign abort    = nAS && (state == SETUP || state == STROBE || state == WAITACK);
  // After termination, the CPU negating nAS releases the IOB side.
  assign cpu_done = nAS && (state == TERM || state == BERR);

`ifdef IOB_TIMEOUT_BERR_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
`else
  assign nBERR = 1'b1;
`endif

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state      <= IDLE;
      cnt        <= '0;
      rnw_lat    <= 1'b1;
      uds_sel    <= 1'b0;
      lds_sel    <= 1'b0;
      dtack_meta <= 1'b1;
      dtack_sync <= 1'b1;
      IOB_nAS    <= 1'b1;
      IOB_nUDS   <= 1'b1;
      IOB_nLDS   <= 1'b1;
      IOB_RnW    <= 1'b1;
      IOB_AOE    <= 1'b0;
      nDSACK1    <= 1'b1;
      RDLatch    <= 1'b0;
`ifdef IOB_TIMEOUT_BERR_EN
      tcnt       <= '0;
      nBERR      <= 1'b1;
`endif
    end else begin
      dtack_meta <= IOB_nDTACK;
      dtack_sync <= dtack_meta;
      RDLatch    <= 1'b0;
      if (abort || cpu_done) begin
        IOB_nAS  <= 1'b1;
        IOB_nUDS <= 1'b1;
        IOB_nLDS <= 1'b1;
        IOB_AOE  <= 1'b0;
        IOB_RnW  <= 1'b1;
        nDSACK1  <= 1'b1;
`ifdef IOB_TIMEOUT_BERR_EN
        nBERR    <= 1'b1;
`endif
        cnt      <= '0;
        state    <= RECOVER;
      end else begin
        case (state)
          IDLE: begin
            if (IOCS && !nAS) begin
              rnw_lat <= RnW;
              // A0=1 is always the odd (low) lane. Only a byte at A0=0 stays on the upper lane.
              uds_sel <= ~A0;
              lds_sel <= A0 | (SIZ != 2'b01);
              IOB_AOE <= 1'b1;
              IOB_RnW <= RnW;
              cnt     <= '0;
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (cnt == SETUP_LAST) begin
              IOB_nAS <= 1'b0;
              // Read strobes go out together with the address strobe.
              if (rnw_lat) begin
                IOB_nUDS <= ~uds_sel;
                IOB_nLDS <= ~lds_sel;
              end
              state <= STROBE;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          STROBE: begin
            // Write strobes trail the address strobe by one cycle.
            if (!rnw_lat) begin
              IOB_nUDS <= ~uds_sel;
              IOB_nLDS <= ~lds_sel;
            end
`ifdef IOB_TIMEOUT_BERR_EN
            tcnt <= '0;
`endif
            state <= WAITACK;
          end
          WAITACK: begin
            // Ack takes priority over the timeout on the same edge.
            if (ack) begin
              nDSACK1 <= 1'b0;
              RDLatch <= rnw_lat;
              state   <= TERM;
            end
`ifdef IOB_TIMEOUT_BERR_EN
            else if (tcnt == TIMEOUT_LAST) begin
              nBERR    <= 1'b0;
              IOB_nAS  <= 1'b1;
              IOB_nUDS <= 1'b1;
              IOB_nLDS <= 1'b1;
              state    <= BERR;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
`endif
          end
          TERM, BERR: begin
          end
          RECOVER: begin
            if (cnt == RECOVER_LAST) state <= IDLE;
            else                     cnt   <= cnt + 3'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iob_cycle_engine.sv
// tb_iob_cycle_engine
//   Timeline model: each transaction's outcome comes from the edges at which
//   the CPU strobe rises, the acknowledge becomes visible, and the watchdog
//   would fire. Every output is then a window over those edges.
`timescale 1ns/1ps
module tb_iob_cycle_engine;

  localparam int S = 1;
  localparam int R = 2;
`ifdef IOB_TIMEOUT_BERR_EN
  localparam int T      = 16;
  localparam bit HAS_TO = 1'b1;
`else
  localparam int T      = 255;
  localparam bit HAS_TO = 1'b0;
`endif
  localparam int NEVER = 1 << 30;
  localparam logic [7:0] IDLE_OUT = 8'b1111_0110;

  logic       CLK = 1'b0;
  logic       nRES = 1'b0;
  logic       IOCS = 1'b0;
  logic       nAS = 1'b1;
  logic       RnW = 1'b1;
  logic [1:0] SIZ = 2'b00;
  logic       A0 = 1'b0;
  logic       IOB_nDTACK = 1'b1;
  logic       IOB_nAS, IOB_nUDS, IOB_nLDS, IOB_RnW, IOB_AOE, nDSACK1, nBERR, RDLatch;

  iob_cycle_engine #(.SETUP_CYCLES(S), .RECOVER_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .nRES(nRES), .IOCS(IOCS), .nAS(nAS), .RnW(RnW), .SIZ(SIZ), .A0(A0),
    .IOB_nDTACK(IOB_nDTACK), .IOB_nAS(IOB_nAS), .IOB_nUDS(IOB_nUDS), .IOB_nLDS(IOB_nLDS),
    .IOB_RnW(IOB_RnW), .IOB_AOE(IOB_AOE), .nDSACK1(nDSACK1), .nBERR(nBERR), .RDLatch(RDLatch)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp_out = IDLE_OUT;
  logic [7:0] act;
  logic [7:0] prev_act = IDLE_OUT;
  int         cur = 0;
  int         obs_edge = 0;
  int         ready_edge = 0;
  int         next_req_min = 0;
  int         nas_fall, nas_rise, uds_fall, lds_fall, dsack_fall, berr_fall, rdl_cnt;

  assign act = {IOB_nAS, IOB_nUDS, IOB_nLDS, IOB_RnW, IOB_AOE, nDSACK1, nBERR, RDLatch};

  // Single per-cycle compare against the model, plus event trackers for the pinned checks.
  always @(negedge CLK) begin
    if (chk_en) begin
      total++;
      if (act !== exp_out) begin
        bad++;
        $display("FAIL outs edge=%0d {nAS,nUDS,nLDS,RnW,AOE,nDSACK1,nBERR,RDLatch} got=%b want=%b",
                 obs_edge, act, exp_out);
      end
      if (prev_act[7] && !act[7]) nas_fall = obs_edge;
      if (!prev_act[7] && act[7]) nas_rise = obs_edge;
      if (prev_act[6] && !act[6]) uds_fall = obs_edge;
      if (prev_act[5] && !act[5]) lds_fall = obs_edge;
      if (prev_act[2] && !act[2]) dsack_fall = obs_edge;
      if (prev_act[1] && !act[1]) berr_fall = obs_edge;
      if (act[0]) rdl_cnt++;
    end
    prev_act = act;
  end

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic clr_trk();
    nas_fall = -1; nas_rise = -1; uds_fall = -1; lds_fall = -1;
    dsack_fall = -1; berr_fall = -1; rdl_cnt = 0;
  endtask

  task automatic tick(input logic [7:0] e_out);
    @(posedge CLK);
    #1;
    obs_edge = cur;
    exp_out  = e_out;
    cur++;
  endtask

  // d_rel : edge (relative to accept) where IOB_nDTACK is first sampled low, <0 = none
  // n_rel : edge (relative to accept) where CPU nAS is first sampled high, 0 = after outcome + n_extra
  task automatic run_txn(input int gap, input bit rnw, input logic [1:0] siz, input bit a0,
                         input int d_rel, input int n_rel, input int n_extra, input bit late_ack,
                         output int t0);
    int req, w, d, a, b, n, fin, ss, se, rel, last;
    bit term, berr, u_sel, l_sel, in_req, aoe;
    req = imax(next_req_min + gap, cur);
    t0  = imax(req, ready_edge);
    w   = t0 + S + 2;
    d   = (d_rel < 0) ? NEVER : t0 + d_rel;
    a   = (d == NEVER) ? NEVER : imax(w + 1, d + 2);
    b   = HAS_TO ? w + T : NEVER;
    if (n_rel > 0)                        n = t0 + n_rel;
    else if (a == NEVER && b == NEVER)    n = t0 + 30;
    else                                  n = imin(a, b) + n_extra;
    term = 1'b0; berr = 1'b0;
    if (n <= a && n <= b) fin = n;
    else if (a <= b) begin term = 1'b1; fin = imax(a + 1, n); end
    else             begin berr = 1'b1; fin = imax(b + 1, n); end
    if (late_ack) d = fin + int'($urandom_range(1, 3));
    rel  = (d == NEVER) ? 0 : imax(d, fin) + int'($urandom_range(0, 2));
    if (rel <= d && d != NEVER) rel = d + 1;
    last = imax(fin, rel);
    case ({a0, siz})
      3'b001:  begin u_sel = 1'b1; l_sel = 1'b0; end
      default: begin u_sel = ~a0;  l_sel = 1'b1; end
    endcase
    if (a0) begin u_sel = 1'b0; l_sel = 1'b1; end
    ss = rnw ? t0 + S + 1 : t0 + S + 2;
    se = berr ? b : fin;
    for (int e = cur; e <= last; e++) begin
      in_req = (e >= req && e < n);
      nAS  = ~in_req;
      IOCS = in_req ? 1'b1 : 1'($urandom_range(0, 1));
      if (e == t0) begin RnW = rnw; SIZ = siz; A0 = a0; end
      else begin
        RnW = 1'($urandom_range(0, 1)); SIZ = 2'($urandom_range(0, 3)); A0 = 1'($urandom_range(0, 1));
      end
      IOB_nDTACK = ~(d != NEVER && e >= d && e < rel);
      aoe = (e >= t0 && e < fin);
      tick({~(e >= t0 + S + 1 && e < se),
            ~(u_sel && e >= ss && e < se),
            ~(l_sel && e >= ss && e < se),
            aoe ? rnw : 1'b1,
            aoe,
            ~(term && e >= a && e < fin),
            ~(berr && e >= b && e < fin),
            term && rnw && e == a});
    end
    nAS = 1'b1; IOCS = 1'b0; IOB_nDTACK = 1'b1;
    ready_edge   = fin + R + 1;
    next_req_min = imax(fin + 1, rel + 1);
  endtask

  initial begin
    int t0, r1, req, kind, d_rel, n_rel, n_extra;
    bit late;
    clr_trk();
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outs", int'(act), int'(IDLE_OUT));
    nRES = 1'b1;
    ready_edge = cur; next_req_min = cur;
    exp_out = IDLE_OUT;
    chk_en = 1'b1;

    // Byte read at A0=1, acknowledge falls 3 cycles after IOB_nAS
    clr_trk();
    run_txn(0, 1'b1, 2'b01, 1'b1, 6, 0, 3, 1'b0, t0);
    check("rd_nas_edge", nas_fall - t0, 2);
    check("rd_lds_edge", lds_fall - t0, 2);
    check("rd_uds_unused", uds_fall, -1);
    check("rd_dsack_edge", dsack_fall - t0, 8);
    check("rd_rdlatch_pulses", rdl_cnt, 1);

    // Word write at A0=0
    clr_trk();
    run_txn(2, 1'b0, 2'b10, 1'b0, 5, 0, 2, 1'b0, t0);
    check("wr_uds_lag", uds_fall - nas_fall, 1);
    check("wr_lds_lag", lds_fall - nas_fall, 1);
    check("wr_dsack_edge", dsack_fall - t0, 7);
    check("wr_rdlatch_pulses", rdl_cnt, 0);

    // Back-to-back: second request arrives during RECOVER
    clr_trk();
    run_txn(0, 1'b1, 2'b00, 1'b0, 4, 0, 1, 1'b0, t0);
    r1 = nas_rise;
    run_txn(0, 1'b1, 2'b10, 1'b0, 4, 0, 1, 1'b0, t0);
    check("b2b_nas_gap", nas_fall - r1, S + R + 2);

    // Abort in WAITACK with no ack; the acknowledge arrives late
    clr_trk();
    run_txn(1, 1'b1, 2'b10, 1'b0, -1, S + 4, 0, 1'b1, t0);
    check("abort_dsack", dsack_fall, -1);
    check("abort_rdlatch", rdl_cnt, 0);
    check("abort_nas_rise", nas_rise - t0, S + 4);

    // Abort during SETUP: strobes never assert
    clr_trk();
    run_txn(1, 1'b0, 2'b00, 1'b0, 3, 1, 0, 1'b0, t0);
    check("setup_abort_nas", nas_fall, -1);

    // Reset while in WAITACK
    chk_en = 1'b0;
    req = imax(imax(cur, next_req_min), ready_edge);
    for (int e = cur; e <= req + S + 4; e++) begin
      nAS = ~(e >= req); IOCS = (e >= req); RnW = 1'b1; SIZ = 2'b10; A0 = 1'b0; IOB_nDTACK = 1'b1;
      tick(IDLE_OUT);
    end
    check("pre_reset_outs", int'(act), int'(8'b0001_1110));
    #2;
    nRES = 1'b0; nAS = 1'b1; IOCS = 1'b0;
    #1;
    check("async_reset_outs", int'(act), int'(IDLE_OUT));
    @(posedge CLK);
    #1;
    check("held_reset_outs", int'(act), int'(IDLE_OUT));
    @(posedge CLK);
    #1;
    nRES = 1'b1;
    ready_edge = cur; next_req_min = cur;
    exp_out = IDLE_OUT;
    chk_en = 1'b1;
    clr_trk();
    run_txn(0, 1'b1, 2'b01, 1'b0, 3, 0, 2, 1'b0, t0);
    check("post_reset_dsack", dsack_fall - t0, S + 4);

`ifdef IOB_TIMEOUT_BERR_EN
    // Watchdog with no ack, then ack exactly on the timeout edge
    clr_trk();
    run_txn(1, 1'b1, 2'b10, 1'b0, -1, 0, 3, 1'b0, t0);
    check("to_berr_edge", berr_fall - t0, S + 2 + 16);
    check("to_no_dsack", dsack_fall, -1);
    clr_trk();
    run_txn(1, 1'b1, 2'b10, 1'b0, S + 16, 0, 2, 1'b0, t0);
    check("to_ack_wins_dsack", dsack_fall - t0, S + 2 + 16);
    check("to_ack_wins_berr", berr_fall, -1);
`endif

    // Randomized transactions
    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      late = 1'b0; n_rel = 0; n_extra = int'($urandom_range(1, 4));
      d_rel = int'($urandom_range(0, 10));
      if (kind >= 6 && kind <= 7) n_rel = int'($urandom_range(1, S + 6));
      if (kind == 8) begin d_rel = -1; n_rel = int'($urandom_range(1, S + 5)); late = 1'b1; end
      if (kind == 9) d_rel = -1;
      run_txn(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), d_rel, n_rel, n_extra, late, t0);
    end

    repeat (2) tick(IDLE_OUT);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
